ht_cmd_fifo: RTL

- Command ingress buffer placed directly upstream of the hash-table command slave port.
- Accepts ht_command_t words from a host-side producer over a valid/ready handshake and stores up to DEPTH words.
- Presents the oldest stored word to the hash-table engine as first-word-fall-through (FWFT), from registered outputs.
- Decouples bursty command sources from engine back-pressure and provides occupancy status for flow control and debug.

---
 rtl/ht_cmd_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ht_cmd_fifo.sv
// Hash-table command ingress FIFO: FWFT, registered outputs and ready,
// DEPTH-entry array behind a single output register.
package ht_cmd_pkg;
  typedef struct packed {
    logic [1:0] op;
    logic [5:0] key;
  } ht_command_t;
endpackage

module ht_cmd_fifo
  import ht_cmd_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int CMD_W = $bits(ht_command_t),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic [CMD_W-1:0] in_cmd_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [CMD_W-1:0] out_cmd_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [AW:0]      used_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_used;
  logic             r_out_valid;
  logic [CMD_W-1:0] r_out_cmd;
  logic             r_in_ready;
  logic             r_full;
  logic             r_empty;

  logic        w_push;
  logic        w_pop;
  logic        w_load;
  logic        w_arr_ne;
  logic        w_bypass;
  logic        w_wr;
  logic        w_rd;
  logic [AW:0] w_arr_cnt;
  logic [AW:0] w_used_nxt;

  always_comb begin
    w_push     = in_valid_i & r_in_ready;
    w_pop      = r_out_valid & out_ready_i;
    w_arr_cnt  = r_used - (AW+1)'(r_out_valid);
    w_arr_ne   = (w_arr_cnt != '0);
    // Output stage refills on a pop or whenever it sits empty
    w_load     = w_pop | ~r_out_valid;
    w_rd       = w_load & w_arr_ne;
    w_bypass   = w_load & ~w_arr_ne & w_push;
    w_wr       = w_push & ~w_bypass;
    w_used_nxt = r_used + (AW+1)'(w_push)
               - (AW+1)'(w_pop);
  end

  always_ff @(posedge clk_i) begin
    if (w_wr && !flush_i) begin
      r_mem[r_wptr] <= in_cmd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_used      <= '0;
      r_out_valid <= 1'b0;
      r_out_cmd   <= '0;
      r_in_ready  <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
    end else if (flush_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_used      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_load) begin
        r_out_valid <= w_rd | w_bypass;
        if (w_rd) begin
          r_out_cmd <= r_mem[r_rptr];
        end else if (w_bypass) begin
          r_out_cmd <= in_cmd_i;
        end
      end
      r_used     <= w_used_nxt;
      r_in_ready <= (w_used_nxt != FULL_CNT);
      r_full     <= (w_used_nxt == FULL_CNT);
      r_empty    <= (w_used_nxt == '0);
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_cmd_o   = r_out_cmd;
  assign out_valid_o = r_out_valid;
  assign used_o      = r_used;
  assign full_o      = r_full;
  assign empty_o     = r_empty;

endmodule
